// File: rtl/minilab_pkg.sv
// minilab_pkg: shared data width and counter sizing for the vector-reduce datapath
package minilab_pkg;
  localparam int MINILAB_DW = 8;
  function automatic int cnt_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/a_fifo_mem.sv
// a_fifo_mem: DEPTH x DATA_WIDTH storage, sync write port, registered read port with clear
module a_fifo_mem
  import minilab_pkg::*;
#(
  parameter int DATA_WIDTH = MINILAB_DW,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/a_fifo.sv
// a_fifo: per-row A-operand FIFO with 1-cycle read latency; A_FIFO_ERR_EN adds sticky ovf/udf flags
module a_fifo
  import minilab_pkg::*;
#(
  parameter int DATA_WIDTH = MINILAB_DW,
  parameter int DEPTH = 8,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_wren,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_full,
  input  logic                  i_rden,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_empty,
  output logic [CNT_W-1:0]      o_count,
  output logic                  o_ovf,
  output logic                  o_udf
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic wr_acc, rd_acc;
  assign o_full  = count == CNT_W'(DEPTH);
  assign o_empty = count == '0;
  assign o_count = count;
  // clear suppresses both sides so stale requests cannot touch storage
  assign wr_acc = i_wren && !o_full && !i_clr;
  assign rd_acc = i_rden && !o_empty && !i_clr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end
  a_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(i_clk),
    .rst_n(i_rst_n),
    .clr(i_clr),
    .we(wr_acc),
    .waddr(wr_ptr),
    .wdata(i_wdata),
    .re(rd_acc),
    .raddr(rd_ptr),
    .rdata(o_rdata)
  );
`ifdef A_FIFO_ERR_EN
  logic ovf, udf;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (i_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (i_wren && o_full) ovf <= 1'b1;
      if (i_rden && o_empty) udf <= 1'b1;
    end
  assign o_ovf = ovf;
  assign o_udf = udf;
`else
  assign o_ovf = 1'b0;
  assign o_udf = 1'b0;
`endif
endmodule
